// File: rtl/gtech_fd_pkg.sv
// gtech_fd_pkg
// Shared definitions for the gtech_fd_pipe elastic register pipeline.
//   FD_INIT_ONES : single bit replicated to build the all-ones default INIT value
//   occ_w()      : width of the occupancy counter for a given stage count
package gtech_fd_pkg;

    localparam logic FD_INIT_ONES = 1'b1;

    // Enough bits to count 0..depth occupied stages.
    function automatic int occ_w(input int depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/gtech_fd_stage.sv
// gtech_fd_stage
// One slice of the elastic pipeline: a WIDTH-bit data register plus its valid bit.
// Ports:
//   clk   in   rising-edge clock
//   rst   in   synchronous active-high reset (data <- INIT, valid <- 0)
//   flush in   clears valid; data is left untouched
//   load  in   capture d and become valid (source is known valid when asserted)
//   drain in   contents move downstream this cycle; clear valid unless reloaded
//   d     in   data from the upstream source
//   q     out  registered data
//   valid out  registered valid bit
module gtech_fd_stage
    import gtech_fd_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{FD_INIT_ONES}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             flush,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q,
    output logic             valid
);

    always_ff @(posedge clk) begin
        if (rst) begin
            q     <= INIT;
            valid <= 1'b0;
        end else begin
            // Data is frozen during a flush so the consumer-visible Q stays stable.
            if (load && !flush) begin
                q <= d;
            end
            if (flush) begin
                valid <= 1'b0;
            end else if (load) begin
                valid <= 1'b1;
            end else if (drain) begin
                valid <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/gtech_fd_pipe.sv
// gtech_fd_pipe
// Elastic pipeline register: DEPTH stages of WIDTH-bit flops with per-stage valid
// bits, valid/ready back-pressure, bubble collapsing and a synchronous flush.
// Optional build macro: GTECH_FD_PIPE_OCC_EN adds the OCC occupancy port/counter.
// Ports:
//   CP      in   rising-edge clock
//   RST     in   synchronous active-high reset (wins over FLUSH)
//   FLUSH   in   invalidate all stages next edge; blocks input and output this cycle
//   D       in   input data
//   D_VALID in   producer has data on D
//   D_READY out  D is accepted this cycle (combinational on Q_READY)
//   Q       out  data of the last stage (shown regardless of valid)
//   QN      out  bitwise inverse of Q
//   Q_VALID out  last stage holds valid data
//   Q_READY in   consumer takes Q this cycle
//   OCC     out  number of occupied stages (GTECH_FD_PIPE_OCC_EN only)
module gtech_fd_pipe
    import gtech_fd_pkg::*;
#(
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 2,
    parameter logic [WIDTH-1:0] INIT  = {WIDTH{FD_INIT_ONES}}
) (
    input  logic             CP,
    input  logic             RST,
    input  logic             FLUSH,
    input  logic [WIDTH-1:0] D,
    input  logic             D_VALID,
    output logic             D_READY,
    output logic [WIDTH-1:0] Q,
    output logic [WIDTH-1:0] QN,
    output logic             Q_VALID,
    input  logic             Q_READY
`ifdef GTECH_FD_PIPE_OCC_EN
    ,
    output logic [occ_w(DEPTH)-1:0] OCC
`endif
);

    logic [WIDTH-1:0] data [DEPTH];
    logic [DEPTH-1:0] valid;
    logic [DEPTH-1:0] stage_ready;
    logic [DEPTH-1:0] load;
    logic [DEPTH-1:0] drain;
    logic             in_xfer;

    // Ready chain: stage k can accept when it or any stage downstream of it is
    // empty, or the consumer is taking the last word. Accumulating "any empty"
    // from the output side gives the same result as the recursive chain
    // without a self-referencing vector.
    always_comb begin
        logic any_empty;
        any_empty   = 1'b0;
        stage_ready = '0;
        for (int k = DEPTH - 1; k >= 0; k--) begin
            any_empty      = any_empty | !valid[k];
            stage_ready[k] = any_empty | Q_READY;
        end
    end

    assign D_READY = stage_ready[0] & !FLUSH;
    assign in_xfer = D_VALID & D_READY;

    for (genvar k = 0; k < DEPTH; k++) begin : g_stage
        logic [WIDTH-1:0] src_data;
        logic             src_valid;

        if (k == 0) begin : g_src_in
            assign src_data  = D;
            assign src_valid = in_xfer;
        end else begin : g_src_prev
            assign src_data  = data[k-1];
            assign src_valid = valid[k-1];
        end

        if (k == DEPTH - 1) begin : g_drain_out
            assign drain[k] = valid[k] & Q_READY;
        end else begin : g_drain_mid
            assign drain[k] = valid[k] & stage_ready[k+1];
        end

        assign load[k] = src_valid & stage_ready[k];

        gtech_fd_stage #(
            .WIDTH (WIDTH),
            .INIT  (INIT)
        ) u_stage (
            .clk   (CP),
            .rst   (RST),
            .flush (FLUSH),
            .load  (load[k]),
            .drain (drain[k]),
            .d     (src_data),
            .q     (data[k]),
            .valid (valid[k])
        );
    end

    assign Q       = data[DEPTH-1];
    assign QN      = ~data[DEPTH-1];
    assign Q_VALID = valid[DEPTH-1] & !FLUSH;

`ifdef GTECH_FD_PIPE_OCC_EN
    localparam int OW = occ_w(DEPTH);

    logic          out_xfer;
    logic [OW-1:0] occ;

    assign out_xfer = Q_VALID & Q_READY;

    // Internal stage-to-stage moves never change the count; only the ends do.
    always_ff @(posedge CP) begin
        if (RST || FLUSH) begin
            occ <= '0;
        end else if (in_xfer && !out_xfer) begin
            occ <= occ + OW'(1);
        end else if (out_xfer && !in_xfer) begin
            occ <= occ - OW'(1);
        end
    end

    assign OCC = occ;
`endif

endmodule

// File: tb/tb_gtech_fd_pipe.sv
// tb_gtech_fd_pipe
// Self-checking bench for gtech_fd_pipe (WIDTH=8, DEPTH=3, INIT=8'hFF).
// The reference model is a queue of words in flight, each tagged with its
// position counted from the input side. Each edge every word moves one step
// toward the output unless it would land on the word ahead of it; the oldest
// word stops at the last position until the consumer takes it.
// Build with GTECH_FD_PIPE_OCC_EN defined to also check OCC.
module tb_gtech_fd_pipe;

    localparam int          WIDTH = 8;
    localparam int          DEPTH = 3;
    localparam logic [7:0]  INIT  = 8'hFF;

    logic       CP;
    logic       RST;
    logic       FLUSH;
    logic [7:0] D;
    logic       D_VALID;
    logic       D_READY;
    logic [7:0] Q;
    logic [7:0] QN;
    logic       Q_VALID;
    logic       Q_READY;
`ifdef GTECH_FD_PIPE_OCC_EN
    logic [1:0] OCC;
`endif

    gtech_fd_pipe #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH),
        .INIT  (INIT)
    ) dut (
        .CP      (CP),
        .RST     (RST),
        .FLUSH   (FLUSH),
        .D       (D),
        .D_VALID (D_VALID),
        .D_READY (D_READY),
        .Q       (Q),
        .QN      (QN),
        .Q_VALID (Q_VALID),
        .Q_READY (Q_READY)
`ifdef GTECH_FD_PIPE_OCC_EN
        ,
        .OCC     (OCC)
`endif
    );

    initial CP = 1'b0;
    always #5 CP = ~CP;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Reference model state
    logic [7:0] mq_data [$];
    int         mq_pos  [$];
    logic [7:0] last_q = INIT;

    function automatic logic m_qv();
        if (FLUSH || mq_pos.size() == 0) return 1'b0;
        return mq_pos[0] == DEPTH - 1;
    endfunction

    function automatic logic m_dr();
        return !FLUSH && ((mq_data.size() < DEPTH) || Q_READY);
    endfunction

    // Apply inputs just after an edge; outputs are then sampled mid-cycle.
    task automatic drive(input logic r, input logic f, input logic dv,
                         input logic [7:0] d, input logic qr);
        RST = r; FLUSH = f; D_VALID = dv; D = d; Q_READY = qr;
        #3;
    endtask

    // Advance one clock edge and move the model along with it.
    task automatic advance();
        logic       r, f, push, pop;
        logic [7:0] d;
        int         lim, np;
        r    = RST;
        f    = FLUSH;
        d    = D;
        push = D_VALID && m_dr();
        pop  = m_qv() && Q_READY;
        @(posedge CP);
        #1;
        cyc++;
        if (r) begin
            mq_data.delete();
            mq_pos.delete();
            last_q = INIT;
        end else if (f) begin
            mq_data.delete();
            mq_pos.delete();
        end else begin
            if (pop) begin
                void'(mq_data.pop_front());
                void'(mq_pos.pop_front());
            end
            for (int i = 0; i < mq_pos.size(); i++) begin
                lim = (i == 0) ? DEPTH - 1 : mq_pos[i-1] - 1;
                np  = (mq_pos[i] + 1 < lim) ? mq_pos[i] + 1 : lim;
                if (np == DEPTH - 1 && mq_pos[i] != DEPTH - 1) last_q = mq_data[i];
                mq_pos[i] = np;
            end
            if (push) begin
                mq_data.push_back(d);
                mq_pos.push_back(0);
                if (DEPTH == 1) last_q = d;
            end
        end
    endtask

    task automatic reset_quiet();
        drive(1'b1, 1'b0, 1'b0, 8'h00, 1'b0);
        advance();
    endtask

    task automatic test_reset();
        drive(1'b1, 1'b0, 1'b1, 8'(($urandom)), 1'b0);
        advance();
        for (int i = 0; i < 2; i++) begin
            // second reset cycle, then first cycle after release
            drive(i == 0, 1'b0, 1'b0, 8'h00, 1'b0);
            checks++; if (Q !== 8'hFF) begin errors++; $display("FAIL reset_q cyc %0d got %h exp ff", cyc, Q); end
            checks++; if (QN !== 8'h00) begin errors++; $display("FAIL reset_qn cyc %0d got %h exp 00", cyc, QN); end
            checks++; if (Q_VALID !== 1'b0) begin errors++; $display("FAIL reset_qvalid cyc %0d got %b exp 0", cyc, Q_VALID); end
            checks++; if (D_READY !== 1'b1) begin errors++; $display("FAIL reset_dready cyc %0d got %b exp 1", cyc, D_READY); end
`ifdef GTECH_FD_PIPE_OCC_EN
            checks++; if (OCC !== 2'd0) begin errors++; $display("FAIL reset_occ cyc %0d got %0d exp 0", cyc, OCC); end
`endif
            advance();
        end
    endtask

    task automatic test_streaming();
        int         first_idx = -1;
        int         last_idx  = -1;
        int         nout      = 0;
        logic [7:0] outs [$];
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, i < 6, 8'(i + 1), 1'b1);
            checks++; if (Q_VALID !== m_qv()) begin errors++; $display("FAIL stream_qvalid cyc %0d got %b exp %b", cyc, Q_VALID, m_qv()); end
            checks++; if (D_READY !== m_dr()) begin errors++; $display("FAIL stream_dready cyc %0d got %b exp %b", cyc, D_READY, m_dr()); end
            checks++; if (Q !== last_q) begin errors++; $display("FAIL stream_q cyc %0d got %h exp %h", cyc, Q, last_q); end
            checks++; if (QN !== ~last_q) begin errors++; $display("FAIL stream_qn cyc %0d got %h exp %h", cyc, QN, ~last_q); end
`ifdef GTECH_FD_PIPE_OCC_EN
            checks++; if (OCC !== 2'(mq_data.size())) begin errors++; $display("FAIL stream_occ cyc %0d got %0d exp %0d", cyc, OCC, mq_data.size()); end
`endif
            if (Q_VALID === 1'b1) begin
                if (first_idx < 0) first_idx = i;
                last_idx = i;
                outs.push_back(Q);
            end
            advance();
        end
        // accepted at the end of cycle 0, so visible DEPTH cycles later
        checks++; if (first_idx != DEPTH) begin errors++; $display("FAIL stream_latency got %0d exp %0d", first_idx, DEPTH); end
        nout = outs.size();
        checks++; if (nout != 6 || last_idx - first_idx != 5) begin errors++; $display("FAIL stream_count got %0d span %0d exp 6 span 5", nout, last_idx - first_idx); end
        for (int k = 0; k < nout && k < 6; k++) begin
            checks++; if (outs[k] !== 8'(k + 1)) begin errors++; $display("FAIL stream_order idx %0d got %h exp %h", k, outs[k], 8'(k + 1)); end
        end
    endtask

    task automatic test_backpressure();
        int         acc  = 0;
        logic [7:0] nxt  = 8'h01;
        logic [7:0] outs [$];
        reset_quiet();
        for (int i = 0; i < 11; i++) begin
            drive(1'b0, 1'b0, 1'b1, nxt, i >= 5);
            checks++; if (Q_VALID !== m_qv()) begin errors++; $display("FAIL bp_qvalid cyc %0d got %b exp %b", cyc, Q_VALID, m_qv()); end
            checks++; if (D_READY !== m_dr()) begin errors++; $display("FAIL bp_dready cyc %0d got %b exp %b", cyc, D_READY, m_dr()); end
            checks++; if (Q !== last_q) begin errors++; $display("FAIL bp_q cyc %0d got %h exp %h", cyc, Q, last_q); end
            checks++; if (QN !== ~last_q) begin errors++; $display("FAIL bp_qn cyc %0d got %h exp %h", cyc, QN, ~last_q); end
`ifdef GTECH_FD_PIPE_OCC_EN
            checks++; if (OCC !== 2'(mq_data.size())) begin errors++; $display("FAIL bp_occ cyc %0d got %0d exp %0d", cyc, OCC, mq_data.size()); end
`endif
            if (i == 4) begin
                checks++; if (D_READY !== 1'b0) begin errors++; $display("FAIL bp_full_dready got %b exp 0", D_READY); end
`ifdef GTECH_FD_PIPE_OCC_EN
                checks++; if (OCC !== 2'd3) begin errors++; $display("FAIL bp_full_occ got %0d exp 3", OCC); end
`endif
            end
            if (i == 5) begin
                checks++; if (acc != 3) begin errors++; $display("FAIL bp_accepted got %0d exp 3", acc); end
            end
            if (Q_VALID === 1'b1 && i >= 5) outs.push_back(Q);
            if (D_READY === 1'b1) begin
                acc++;
                nxt++;
            end
            advance();
        end
        checks++; if (outs.size() < 3) begin errors++; $display("FAIL bp_drain_count got %0d exp >=3", outs.size()); end
        for (int k = 0; k < 3 && k < outs.size(); k++) begin
            checks++; if (outs[k] !== 8'(k + 1)) begin errors++; $display("FAIL bp_order idx %0d got %h exp %h", k, outs[k], 8'(k + 1)); end
        end
    endtask

    task automatic test_bubble();
        logic       dv_t [8] = '{1, 0, 0, 1, 0, 0, 0, 0};
        logic [7:0] d_t  [8] = '{8'hA5, 8'h00, 8'h00, 8'h5A, 8'h00, 8'h00, 8'h00, 8'h00};
        logic       qr_t [8] = '{0, 0, 0, 0, 0, 1, 1, 1};
        logic [7:0] outs [$];
        reset_quiet();
        for (int i = 0; i < 8; i++) begin
            drive(1'b0, 1'b0, dv_t[i], d_t[i], qr_t[i]);
            checks++; if (Q_VALID !== m_qv()) begin errors++; $display("FAIL bub_qvalid cyc %0d got %b exp %b", cyc, Q_VALID, m_qv()); end
            checks++; if (D_READY !== m_dr()) begin errors++; $display("FAIL bub_dready cyc %0d got %b exp %b", cyc, D_READY, m_dr()); end
            checks++; if (Q !== last_q) begin errors++; $display("FAIL bub_q cyc %0d got %h exp %h", cyc, Q, last_q); end
            checks++; if (QN !== ~last_q) begin errors++; $display("FAIL bub_qn cyc %0d got %h exp %h", cyc, QN, ~last_q); end
`ifdef GTECH_FD_PIPE_OCC_EN
            checks++; if (OCC !== 2'(mq_data.size())) begin errors++; $display("FAIL bub_occ cyc %0d got %0d exp %0d", cyc, OCC, mq_data.size()); end
`endif
            if (i == 5) begin
                checks++; if (Q_VALID !== 1'b1 || Q !== 8'hA5) begin errors++; $display("FAIL bub_head got v=%b q=%h exp v=1 q=a5", Q_VALID, Q); end
`ifdef GTECH_FD_PIPE_OCC_EN
                checks++; if (OCC !== 2'd2) begin errors++; $display("FAIL bub_held_occ got %0d exp 2", OCC); end
`endif
            end
            if (Q_VALID === 1'b1 && qr_t[i]) outs.push_back(Q);
            advance();
        end
        checks++; if (outs.size() != 2) begin errors++; $display("FAIL bub_count got %0d exp 2", outs.size()); end
        else begin
            checks++; if (outs[0] !== 8'hA5 || outs[1] !== 8'h5A) begin errors++; $display("FAIL bub_order got %h %h exp a5 5a", outs[0], outs[1]); end
        end
    endtask

    task automatic test_flush();
        logic [7:0] w [3];
        logic       f_t  [6] = '{0, 0, 0, 1, 0, 0};
        logic       dv_t [6] = '{1, 1, 1, 1, 0, 0};
        logic       qr_t [6] = '{0, 0, 0, 1, 0, 1};
        for (int k = 0; k < 3; k++) w[k] = 8'($urandom_range(0, 255));
        reset_quiet();
        for (int i = 0; i < 6; i++) begin
            drive(1'b0, f_t[i], dv_t[i], (i < 3) ? w[i] : 8'h77, qr_t[i]);
            checks++; if (Q_VALID !== m_qv()) begin errors++; $display("FAIL fl_qvalid cyc %0d got %b exp %b", cyc, Q_VALID, m_qv()); end
            checks++; if (D_READY !== m_dr()) begin errors++; $display("FAIL fl_dready cyc %0d got %b exp %b", cyc, D_READY, m_dr()); end
            checks++; if (Q !== last_q) begin errors++; $display("FAIL fl_q cyc %0d got %h exp %h", cyc, Q, last_q); end
            checks++; if (QN !== ~last_q) begin errors++; $display("FAIL fl_qn cyc %0d got %h exp %h", cyc, QN, ~last_q); end
`ifdef GTECH_FD_PIPE_OCC_EN
            checks++; if (OCC !== 2'(mq_data.size())) begin errors++; $display("FAIL fl_occ cyc %0d got %0d exp %0d", cyc, OCC, mq_data.size()); end
`endif
            if (i == 3) begin
                checks++; if (D_READY !== 1'b0 || Q_VALID !== 1'b0) begin errors++; $display("FAIL fl_during got dr=%b qv=%b exp 0 0", D_READY, Q_VALID); end
            end
            if (i >= 3) begin
                checks++; if (Q !== w[0]) begin errors++; $display("FAIL fl_qkeep cyc %0d got %h exp %h", cyc, Q, w[0]); end
            end
            if (i == 4) begin
                checks++; if (Q_VALID !== 1'b0) begin errors++; $display("FAIL fl_after_qvalid got %b exp 0", Q_VALID); end
`ifdef GTECH_FD_PIPE_OCC_EN
                checks++; if (OCC !== 2'd0) begin errors++; $display("FAIL fl_after_occ got %0d exp 0", OCC); end
`endif
            end
            advance();
        end
    endtask

    task automatic test_rst_flush();
        logic r_t [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 0};
        logic v_t [10] = '{1, 1, 1, 1, 1, 1, 0, 0, 0, 0};
        reset_quiet();
        for (int i = 0; i < 10; i++) begin
            drive(r_t[i], r_t[i], v_t[i], 8'($urandom_range(0, 254)), 1'b1);
            checks++; if (Q_VALID !== m_qv()) begin errors++; $display("FAIL rf_qvalid cyc %0d got %b exp %b", cyc, Q_VALID, m_qv()); end
            checks++; if (D_READY !== m_dr()) begin errors++; $display("FAIL rf_dready cyc %0d got %b exp %b", cyc, D_READY, m_dr()); end
            checks++; if (Q !== last_q) begin errors++; $display("FAIL rf_q cyc %0d got %h exp %h", cyc, Q, last_q); end
            checks++; if (QN !== ~last_q) begin errors++; $display("FAIL rf_qn cyc %0d got %h exp %h", cyc, QN, ~last_q); end
`ifdef GTECH_FD_PIPE_OCC_EN
            checks++; if (OCC !== 2'(mq_data.size())) begin errors++; $display("FAIL rf_occ cyc %0d got %0d exp %0d", cyc, OCC, mq_data.size()); end
`endif
            if (i == 5) begin
                checks++; if (Q !== INIT || QN !== ~INIT || Q_VALID !== 1'b0 || D_READY !== 1'b1) begin
                    errors++; $display("FAIL rf_post_reset got q=%h qn=%h qv=%b dr=%b exp ff 00 0 1", Q, QN, Q_VALID, D_READY);
                end
            end
            advance();
        end
    endtask

    task automatic test_random();
        logic r, f, dv, qr;
        reset_quiet();
        for (int i = 0; i < 400; i++) begin
            r  = ($urandom % 100) == 0;
            f  = ($urandom % 20) == 0;
            dv = ($urandom % 4) != 0;
            qr = ($urandom % 3) != 0;
            drive(r, f, dv, 8'($urandom), qr);
            checks++; if (Q_VALID !== m_qv()) begin errors++; $display("FAIL rnd_qvalid cyc %0d got %b exp %b", cyc, Q_VALID, m_qv()); end
            checks++; if (D_READY !== m_dr()) begin errors++; $display("FAIL rnd_dready cyc %0d got %b exp %b", cyc, D_READY, m_dr()); end
            checks++; if (Q !== last_q) begin errors++; $display("FAIL rnd_q cyc %0d got %h exp %h", cyc, Q, last_q); end
            checks++; if (QN !== ~last_q) begin errors++; $display("FAIL rnd_qn cyc %0d got %h exp %h", cyc, QN, ~last_q); end
`ifdef GTECH_FD_PIPE_OCC_EN
            checks++; if (OCC !== 2'(mq_data.size())) begin errors++; $display("FAIL rnd_occ cyc %0d got %0d exp %0d", cyc, OCC, mq_data.size()); end
`endif
            advance();
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        RST = 1'b1; FLUSH = 1'b0; D = 8'h00; D_VALID = 1'b0; Q_READY = 1'b0;
        test_reset();
        test_streaming();
        test_backpressure();
        test_bubble();
        test_flush();
        test_rst_flush();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
